// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives a req/ack fetch from the current PC, loads the IF/ID register,
// absorbs ID stalls with a one-entry buffer and discards fetches killed by flushes.
module if_fetch_stage #(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               pc_hold_o,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_data_i,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic [ADDR_W-1:0]  ifid_pc4_o,
   output logic [INSTR_W-1:0] ifid_instr_o,
   output logic               ifid_valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t             state, state_nx;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  buf_pc4;
   logic [INSTR_W-1:0] buf_instr;
   logic [ADDR_W-1:0]  pc4;
   logic               req_q;
   logic               kill, load_fetch, load_from_buf, load_buf, bubble;

   assign pc4        = pc_i + ADDR_W'(32'd4);
   assign imem_req_o = req_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start_i) state_nx = FETCH;
         FETCH: begin
            if (flush_i)                      state_nx = imem_ack_i ? FETCH : DROP;
            else if (stall_i && imem_ack_i)   state_nx = HOLD;
         end
         HOLD:  if (flush_i || !stall_i) state_nx = FETCH;
         DROP:  if (imem_ack_i) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      pc_hold_o     = 1'b1;
      imem_addr_o   = pc_i;
      kill          = 1'b0;
      load_fetch    = 1'b0;
      load_from_buf = 1'b0;
      load_buf      = 1'b0;
      bubble        = 1'b0;
      unique case (state)
         FETCH: begin
            if (flush_i) begin
               pc_hold_o = 1'b0;
               kill      = 1'b1;
            end else if (stall_i) begin
               load_buf = imem_ack_i;
            end else if (imem_ack_i) begin
               pc_hold_o  = 1'b0;
               load_fetch = 1'b1;
            end else begin
               bubble = 1'b1;
            end
         end
         HOLD: begin
            if (flush_i) begin
               pc_hold_o = 1'b0;
               kill      = 1'b1;
            end else if (!stall_i) begin
               pc_hold_o     = 1'b0;
               load_from_buf = 1'b1;
            end
         end
         DROP: begin
            // keep the abandoned address on the bus until memory completes the handshake
            imem_addr_o = addr_q;
            pc_hold_o   = !flush_i;
            kill        = flush_i;
            bubble      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_q        <= 1'b0;
         addr_q       <= '0;
         buf_instr    <= NOP_INSTR;
         buf_pc4      <= '0;
         ifid_valid_o <= 1'b0;
         ifid_instr_o <= NOP_INSTR;
         ifid_pc4_o   <= '0;
      end else begin
         req_q <= (state_nx == FETCH) || (state_nx == DROP);
         if (state == FETCH) addr_q <= pc_i;
         if (load_buf) begin
            buf_instr <= imem_data_i;
            buf_pc4   <= pc4;
         end
         if (kill) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
         end else if (load_fetch) begin
            ifid_valid_o <= 1'b1;
            ifid_instr_o <= imem_data_i;
            ifid_pc4_o   <= pc4;
         end else if (load_from_buf) begin
            ifid_valid_o <= 1'b1;
            ifid_instr_o <= buf_instr;
            ifid_pc4_o   <= buf_pc4;
         end else if (bubble) begin
            ifid_valid_o <= 1'b0;
         end
      end
   end

endmodule
